// File: rtl/accum_pkg.sv
// Shared types and sizing for the two-requester accumulator.
// The arbiter, adder and top all agree on these definitions.
package accum_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ACC_WIDTH  = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage

// File: rtl/lookahead_adder.sv
// Carry-lookahead adder built from 4-bit groups.
// Group generate/propagate let the carry bypass each group.
module lookahead_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic carry;
        logic gcin;
        logic gg;
        logic pg;
        s     = '0;
        carry = cin;
        gcin  = 1'b0;
        gg    = 1'b0;
        pg    = 1'b1;
        for (int base = 0; base < WIDTH; base += 4) begin
            gcin = carry;
            gg   = 1'b0;
            pg   = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (base + k < WIDTH) begin
                    s[base+k] = p[base+k] ^ carry;
                    carry     = g[base+k] | (p[base+k] & carry);
                    gg        = g[base+k] | (p[base+k] & gg);
                    pg        = pg & p[base+k];
                end
            end
            // Carry out of the group comes from group G/P, not the bit chain.
            carry = gg | (pg & gcin);
        end
        cout = carry;
    end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the last winner loses a tie.
// last_grant moves only when the granted request is actually accepted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant[1];
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/accum_arbiter.sv
// Shares one adder and accumulator between two valid/ready requesters.
// Handshake: a request is taken on the edge where req_valid_i & req_ready_o.
module accum_arbiter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear_i,
    input  logic [1:0]                 req_valid_i,
    input  logic [1:0]                 req_sub_i,
    input  logic [1:0][DATA_WIDTH-1:0] req_data_i,
    output logic [1:0]                 req_ready_o,
    output logic [DATA_WIDTH:0]        acc_o,
    output logic                       ovf_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       done_id_o
);

    import accum_pkg::*;

    localparam int ACC_W = DATA_WIDTH + 1;

    state_t                state_q,   state_d;
    logic [DATA_WIDTH-1:0] op_q,      op_d;
    op_t                   sub_q,     sub_d;
    logic                  id_q,      id_d;
    logic [ACC_W-1:0]      acc_q,     acc_d;
    logic                  ovf_q,     ovf_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    logic                  done_id_q, done_id_d;

    logic [1:0]            arb_req;
    logic [1:0]            grant;
    logic                  accept;

    logic [DATA_WIDTH-1:0] add_a;
    logic [DATA_WIDTH-1:0] add_b;
    logic                  add_cin;
    logic [DATA_WIDTH-1:0] add_s;
    logic                  add_cout;

    // Requests only reach the arbiter in IDLE, so ready is never speculative.
    assign arb_req     = (state_q == IDLE) ? req_valid_i : 2'b00;
    assign accept      = |grant;
    assign req_ready_o = grant;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (arb_req),
        .accept (accept),
        .grant  (grant)
    );

    assign add_cin = (sub_q == OP_SUB);
    assign add_a   = add_cin ? ~op_q : op_q;
    assign add_b   = acc_q[DATA_WIDTH-1:0];

    lookahead_adder #(
        .WIDTH (DATA_WIDTH)
    ) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_cout)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sub_d     = sub_q;
        id_d      = id_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        done_id_d = done_id_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d    = grant[1];
                    op_d    = req_data_i[grant[1]];
                    sub_d   = req_sub_i[grant[1]] ? OP_SUB : OP_ADD;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Top bit is carry for add, borrow (inverted carry) for subtract.
                acc_d = {add_cin ? ~add_cout : add_cout, add_s};
                if ((add_a[DATA_WIDTH-1] == add_b[DATA_WIDTH-1]) &&
                    (add_s[DATA_WIDTH-1] != add_a[DATA_WIDTH-1])) begin
                    ovf_d = 1'b1;
                end
                done_id_d = id_q;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear beats writeback but never stalls the FSM or a grant.
        if (clear_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            sub_q     <= OP_ADD;
            id_q      <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            sub_q     <= sub_d;
            id_q      <= id_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign acc_o     = acc_q;
    assign ovf_o     = ovf_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign done_id_o = done_id_q;

endmodule

// File: tb/tb_accum_arbiter.sv
// Directed bench for accum_arbiter: the driver queues the expected completion
// {id, ovf, acc} per request and a monitor compares it at every done_o pulse.
module tb_accum_arbiter;

    localparam int DW = 16;
    localparam int EW = DW + 3;

    logic               clk;
    logic               reset;
    logic               clear_i;
    logic [1:0]         req_valid_i;
    logic [1:0]         req_sub_i;
    logic [1:0][DW-1:0] req_data_i;
    logic [1:0]         req_ready_o;
    logic [DW:0]        acc_o;
    logic               ovf_o;
    logic               busy_o;
    logic               done_o;
    logic               done_id_o;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    accum_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (clear_i),
        .req_valid_i (req_valid_i),
        .req_sub_i   (req_sub_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .acc_o       (acc_o),
        .ovf_o       (ovf_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .done_id_o   (done_id_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset && done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("done_acc", 32'(acc_o), 32'(e[DW:0]));
                check("done_ovf", 32'(ovf_o), 32'(e[DW+1]));
                check("done_id",  32'(done_id_o), 32'(e[DW+2]));
                check("done_busy", 32'(busy_o), 32'd1);
            end
        end
    end

    // driver tasks
    task automatic wait_accept(input int id);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready_o != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_seen", 32'(ok), 32'd1);
        check("ready_onehot", 32'(req_ready_o), 32'(2'b01 << id));
        @(posedge clk);
        #1;
        req_valid_i = 2'b00;
    endtask

    task automatic do_op(input int id, input bit sub, input logic [DW-1:0] data,
                         input logic [DW:0] exp_acc, input bit exp_ovf);
        exp_q.push_back({id[0], exp_ovf, exp_acc});
        req_sub_i[id]   = sub;
        req_data_i[id]  = data;
        req_valid_i[id] = 1'b1;
        wait_accept(id);
        @(posedge clk);
        #1;
        check("done_latency", 32'(done_o), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
    endtask

    initial begin
        int last_cyc;
        reset       = 1'b1;
        clear_i     = 1'b0;
        req_valid_i = 2'b00;
        req_sub_i   = 2'b00;
        req_data_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc",   32'(acc_o), 32'd0);
        check("rst_ovf",   32'(ovf_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_done",  32'(done_o), 32'd0);
        check("rst_id",    32'(done_id_o), 32'd0);
        check("rst_ready", 32'(req_ready_o), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // simple add, then build 0x7FFF and overflow into 0x8000
        do_op(0, 1'b0, 16'h0005, 17'h00005, 1'b0);
        do_op(0, 1'b0, 16'h7FFA, 17'h07FFF, 1'b0);
        do_op(1, 1'b0, 16'h0001, 17'h08000, 1'b1);
        pulse_clear();
        check("clr_acc", 32'(acc_o), 32'd0);
        check("clr_ovf", 32'(ovf_o), 32'd0);

        // subtract with borrow
        do_op(1, 1'b0, 16'h0003, 17'h00003, 1'b0);
        do_op(0, 1'b1, 16'h0005, 17'h1FFFE, 1'b0);
        pulse_clear();
        check("clr2_acc", 32'(acc_o), 32'd0);

        // leave last_grant at 1 so the tie sequence starts with requester 0
        do_op(1, 1'b0, 16'h0000, 17'h00000, 1'b0);

        // six accepts under a continuous tie
        req_sub_i      = 2'b00;
        req_data_i[0]  = 16'h0001;
        req_data_i[1]  = 16'h0001;
        req_valid_i    = 2'b11;
        last_cyc       = 0;
        for (int k = 0; k < 6; k++) begin
            bit ok;
            ok = 1'b0;
            exp_q.push_back({k[0], 1'b0, 17'(k + 1)});
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (req_ready_o != 2'b00) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("tie_accept", 32'(ok), 32'd1);
            check("tie_grant", 32'(req_ready_o), 32'(2'b01 << k[0]));
            if (k > 0) check("tie_spacing", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            @(posedge clk);
            #1;
            if (k == 5) req_valid_i = 2'b00;
        end
        repeat (2) @(posedge clk);
        #1;
        check("tie_final_acc", 32'(acc_o), 32'd6);

        // clear during EXEC discards the result but still completes
        pulse_clear();
        do_op(0, 1'b0, 16'h0020, 17'h00020, 1'b0);
        exp_q.push_back({1'b1, 1'b0, 17'h00000});
        req_sub_i[1]   = 1'b0;
        req_data_i[1]  = 16'h0010;
        req_valid_i[1] = 1'b1;
        wait_accept(1);
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        check("clr_exec_done", 32'(done_o), 32'd1);
        @(posedge clk);
        #1;

        // reset in the middle of EXEC drops the op
        do_op(0, 1'b0, 16'h0030, 17'h00030, 1'b0);
        req_sub_i[0]   = 1'b0;
        req_data_i[0]  = 16'h0007;
        req_valid_i[0] = 1'b1;
        wait_accept(0);
        check("pre_rst_busy", 32'(busy_o), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_acc",  32'(acc_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_done", 32'(done_o), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_idle_done", 32'(done_o), 32'd0);
        check("post_rst_acc", 32'(acc_o), 32'd0);

        // first tie after reset goes to requester 0
        exp_q.push_back({1'b0, 1'b0, 17'h00001});
        req_data_i[0] = 16'h0001;
        req_data_i[1] = 16'h0001;
        req_valid_i   = 2'b11;
        wait_accept(0);
        repeat (3) @(posedge clk);
        #1;

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/accum_arbiter.md
# accum_arbiter

Round-robin controller that shares one adder and one accumulator register between two requesters. Each requester presents an add or subtract operand over a valid/ready handshake. The block grants one requester at a time, drives the shared lookahead adder, and writes the result back. It then pulses a completion strobe tagged with the winner's ID. It sits between the switch/button front end (or a future bus master) and the hex display path, and replaces the single-user run-to-load accumulator loop.

## Interface
Parameters:
- DATA_WIDTH, 16, operand width; the accumulator is DATA_WIDTH+1 bits, with the top bit holding carry/borrow.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear_i  in  1  synchronous clear of the accumulator and overflow flag.
- req_valid_i  in  2  per-requester operand valid.
- req_sub_i  in  2  per-requester op select; 0 = add, 1 = subtract.
- req_data_i  in  2×DATA_WIDTH  per-requester operand, packed [1:0][DATA_WIDTH-1:0].
- req_ready_o  out  2  one-hot accept strobe; handshake completes when valid & ready.
- acc_o  out  DATA_WIDTH+1  accumulator contents.
- ovf_o  out  1  sticky signed overflow (16-bit two's complement).
- busy_o  out  1  high in EXEC and DONE.
- done_o  out  1  one-cycle completion pulse.
- done_id_o  out  1  requester index of the completed op; valid when done_o is high.

## Operation
- States: IDLE, EXEC, DONE.
  - IDLE: if any req_valid_i is high, grant one requester, assert its req_ready_o for that cycle, capture operand and op into op_q/sub_q/id_q, then go to EXEC. Otherwise stay in IDLE.
  - EXEC: adder a = sub_q ? ~op_q : op_q; b = acc[15:0]; cin = sub_q. At the clock edge, acc <= {sub_q ? ~cout : cout, s}. Go to DONE.
  - DONE: done_o = 1 and done_id_o = id_q. Return to IDLE; no grant is made in this cycle.
- Arbitration:
  - Only one valid requester: that requester wins.
  - Both valid: the requester not granted last time wins.
  - last_grant updates only on a completed handshake.
  - last_grant resets to 1, so requester 0 wins the first tie.
- req_ready_o is asserted only in IDLE, never speculatively, and is combinational on req_valid_i and last_grant.
- A requester must hold valid and data stable until ready. Deasserting valid before ready is legal and cancels the request.
- Overflow: in EXEC, ovf_o is set if the operand sign bits (after inversion for subtract) are equal and the result sign differs. It stays set until clear_i or reset.
- clear_i:
  - In any state it sets acc to 0 and ovf to 0 on the next edge.
  - In EXEC, clear wins over writeback and the result is discarded. The FSM still goes to DONE and pulses done_o with the same ID.
  - In IDLE with a valid request, the grant still happens; the clear and the grant occur on the same edge.
- Reset at any point: all state returns to reset values, and any in-flight op is dropped with no done_o pulse.

## Timing
- Reset values: state = IDLE, acc_o = 0, ovf_o = 0, busy_o = 0, done_o = 0, done_id_o = 0, req_ready_o = 0, last_grant = 1.
- Accept in cycle N. acc_o shows the new value in cycle N+2, coincident with done_o.
- Throughput: one op per 3 cycles under continuous requests.
- acc_o, ovf_o, done_o, done_id_o, and busy_o are all registered. req_ready_o is combinational.

## Structure
- Package accum_pkg holds:
  - typedef enum state_t {IDLE, EXEC, DONE};
  - localparam ACC_WIDTH = DATA_WIDTH+1;
  - typedef enum logic {OP_ADD, OP_SUB} op_t.
- One new sub-module, rr_arbiter2: a 2-way round-robin grant with last_grant register, inputs req[1:0] and accept, output grant one-hot.
- The shared adder is an instance of the existing lookahead_adder (16-bit, cin, cout). Swapping it for ripple_adder or select_adder must require no other change.

## Test plan
- Reset, then req0 adds 0x0005 -> ready[0] in the accept cycle; done_o with id 0 two cycles later; acc_o = 0x00005; ovf_o = 0.
- acc = 0x7FFF, req1 adds 0x0001 -> acc_o = 0x08000, ovf_o = 1. A following clear_i gives acc_o = 0, ovf_o = 0.
- acc = 0x00003, req0 subtracts 0x0005 -> acc_o = {1, 0xFFFE} (borrow set); ovf_o = 0.
- Both requesters hold valid with +1 for 6 accepts -> grants alternate 0,1,0,1,0,1; acc_o = 0x00006; done_o every 3 cycles.
- clear_i asserted during EXEC of +0x0010 on acc 0x00020 -> acc_o = 0 in DONE; done_o still pulses with the correct id.
- reset asserted mid-EXEC -> outputs take reset values immediately; no done_o pulse; the next tie is won by requester 0.
